// File: rtl/b01_scan_ctrl.sv
`timescale 1ns/1ps
// b01_scan_ctrl: applies one stored test pattern to the b01 core, holds the core
// inputs for SETTLE_CYC cycles, captures the core response, compares it with
// the expected response and hands the result out over a valid/ready channel.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start_vld/rdy      pattern request handshake (pat_pi, pat_state, exp_ppo, exp_po)
//   core_pi/core_ppi   stimulus to core G1/G2 and G112..G116 (zero when not applying)
//   core_ppo/core_po   core response G10..G13 and G24
//   rsp_vld/rdy        response handshake (rsp_ppo, rsp_po, rsp_fail)
//   cnt_clr            synchronous clear of pat_cnt/fail_cnt
//   pat_cnt/fail_cnt   saturating counts of completed and failing patterns
module b01_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 2   // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_vld,
  output logic        start_rdy,
  input  logic [1:0]  pat_pi,
  input  logic [4:0]  pat_state,
  input  logic [3:0]  exp_ppo,
  input  logic        exp_po,
  output logic [1:0]  core_pi,
  output logic [4:0]  core_ppi,
  input  logic [3:0]  core_ppo,
  input  logic        core_po,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [3:0]  rsp_ppo,
  output logic        rsp_po,
  output logic        rsp_fail,
  input  logic        cnt_clr,
  output logic [15:0] pat_cnt,
  output logic [15:0] fail_cnt
);

  localparam int unsigned SET_W = 4;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, RESP} state_t;

  state_t           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [3:0]       exp_ppo_q;
  logic             exp_po_q;
  logic             accept;
  logic             capture;
  logic             mismatch;

  // Next-state logic; accept/capture mark the edges that load or retire a pattern
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    accept   = 1'b0;
    capture  = 1'b0;
    mismatch = {core_ppo, core_po} != {exp_ppo_q, exp_po_q};
    case (state_q)
      IDLE: begin
        if (start_vld) begin
          state_d  = APPLY;
          settle_d = SETTLE_LOAD;
          accept   = 1'b1;
        end
      end
      APPLY: begin
        if (settle_q == '0) begin
          state_d = CAPTURE;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      CAPTURE: begin
        state_d = RESP;
        capture = 1'b1;
      end
      RESP: begin
        if (rsp_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, handshake flags and pattern registers; core inputs are the pattern
  // registers themselves, cleared on capture so they read zero in RESP/IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      start_rdy <= 1'b1;
      rsp_vld   <= 1'b0;
      core_pi   <= '0;
      core_ppi  <= '0;
      exp_ppo_q <= '0;
      exp_po_q  <= 1'b0;
      rsp_ppo   <= '0;
      rsp_po    <= 1'b0;
      rsp_fail  <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      start_rdy <= (state_d == IDLE);
      rsp_vld   <= (state_d == RESP);
      if (accept) begin
        core_pi   <= pat_pi;
        core_ppi  <= pat_state;
        exp_ppo_q <= exp_ppo;
        exp_po_q  <= exp_po;
      end else if (capture) begin
        core_pi  <= '0;
        core_ppi <= '0;
      end
      if (capture) begin
        rsp_ppo  <= core_ppo;
        rsp_po   <= core_po;
        rsp_fail <= mismatch;
      end
    end
  end

  // Saturating pattern/fail counters; clear wins over a same-edge increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_cnt  <= '0;
      fail_cnt <= '0;
    end else if (cnt_clr) begin
      pat_cnt  <= '0;
      fail_cnt <= '0;
    end else if (capture) begin
      if (pat_cnt != CNT_MAX) begin
        pat_cnt <= pat_cnt + CNT_W'(1);
      end
      if (mismatch && (fail_cnt != CNT_MAX)) begin
        fail_cnt <= fail_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_b01_scan_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for b01_scan_ctrl: randomized patterns against a
// transaction-level model (latency formula, core stub function, saturating
// integer counters), plus directed reset, hold, saturation and throughput cases.
module tb_b01_scan_ctrl;

  localparam int unsigned S  = 2;
  localparam int unsigned S1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // main instance (SETTLE_CYC = 2)
  logic        start_vld, start_rdy, rsp_vld, rsp_rdy, cnt_clr;
  logic [1:0]  pat_pi, core_pi;
  logic [4:0]  pat_state, core_ppi;
  logic [3:0]  exp_ppo, core_ppo, rsp_ppo;
  logic        exp_po, core_po, rsp_po, rsp_fail;
  logic [15:0] pat_cnt, fail_cnt;

  // throughput instance (SETTLE_CYC = 1, rsp_rdy tied high)
  logic        start_vld1, start_rdy1, rsp_vld1;
  logic [1:0]  pat_pi1, core_pi1;
  logic [4:0]  pat_state1, core_ppi1;
  logic [3:0]  core_ppo1, rsp_ppo1;
  logic        core_po1, rsp_po1, rsp_fail1;
  logic [15:0] pat_cnt1, fail_cnt1;

  // core stub: next state = inverted present state, G24 = G2 ^ G116
  assign core_ppo  = ~core_ppi[3:0];
  assign core_po   = core_pi[1] ^ core_ppi[4];
  assign core_ppo1 = ~core_ppi1[3:0];
  assign core_po1  = core_pi1[1] ^ core_ppi1[4];

  b01_scan_ctrl #(.SETTLE_CYC(S)) u_dut (
    .clk(clk), .rst(rst), .start_vld(start_vld), .start_rdy(start_rdy),
    .pat_pi(pat_pi), .pat_state(pat_state), .exp_ppo(exp_ppo), .exp_po(exp_po),
    .core_pi(core_pi), .core_ppi(core_ppi), .core_ppo(core_ppo), .core_po(core_po),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_ppo(rsp_ppo), .rsp_po(rsp_po),
    .rsp_fail(rsp_fail), .cnt_clr(cnt_clr), .pat_cnt(pat_cnt), .fail_cnt(fail_cnt)
  );

  b01_scan_ctrl #(.SETTLE_CYC(S1)) u_dut1 (
    .clk(clk), .rst(rst), .start_vld(start_vld1), .start_rdy(start_rdy1),
    .pat_pi(pat_pi1), .pat_state(pat_state1), .exp_ppo(4'b0000), .exp_po(1'b0),
    .core_pi(core_pi1), .core_ppi(core_ppi1), .core_ppo(core_ppo1), .core_po(core_po1),
    .rsp_vld(rsp_vld1), .rsp_rdy(1'b1), .rsp_ppo(rsp_ppo1), .rsp_po(rsp_po1),
    .rsp_fail(rsp_fail1), .cnt_clr(1'b0), .pat_cnt(pat_cnt1), .fail_cnt(fail_cnt1)
  );

  int total = 0;
  int bad   = 0;
  int pat_m = 0;
  int fail_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One full transaction; hold = cycles rsp_rdy stays low in RESP,
  // spam = keep start_vld high throughout, clr = pulse cnt_clr on capture exit
  task automatic do_pat(input logic [1:0] pi, input logic [4:0] st, input logic [3:0] eppo,
                        input logic epo, input int hold, input bit spam, input bit clr);
    logic [3:0] rppo;
    logic       rpo, rfail;
    int         n;
    rppo  = ~st[3:0];
    rpo   = pi[1] ^ st[4];
    rfail = ({rppo, rpo} != {eppo, epo});
    check("idle_rdy", 32'(start_rdy), 32'd1);
    pat_pi = pi; pat_state = st; exp_ppo = eppo; exp_po = epo;
    start_vld = 1'b1; rsp_rdy = 1'b0;
    @(posedge clk); n = 1;
    @(negedge clk);
    start_vld = spam;
    pat_pi = 2'($urandom); pat_state = 5'($urandom);
    exp_ppo = 4'($urandom); exp_po = 1'($urandom);
    check("apply_pi", 32'(core_pi), 32'(pi));
    check("apply_ppi", 32'(core_ppi), 32'(st));
    check("busy_rdy", 32'(start_rdy), 32'd0);
    while (!rsp_vld && n < int'(3 * S + 10)) begin
      cnt_clr = clr && (n == int'(S + 1));
      @(posedge clk); n++;
      @(negedge clk);
      cnt_clr = 1'b0;
      if (!rsp_vld) check("held_ppi", 32'(core_ppi), 32'(st));
    end
    check("latency", 32'(n), 32'(S + 2));
    check("rsp_ppo", 32'(rsp_ppo), 32'(rppo));
    check("rsp_po", 32'(rsp_po), 32'(rpo));
    check("rsp_fail", 32'(rsp_fail), 32'(rfail));
    if (clr) begin
      pat_m = 0; fail_m = 0;
    end else begin
      if (pat_m < 65535) pat_m++;
      if (rfail && fail_m < 65535) fail_m++;
    end
    check("pat_cnt", 32'(pat_cnt), 32'(pat_m));
    check("fail_cnt", 32'(fail_cnt), 32'(fail_m));
    check("resp_pi_zero", 32'({core_pi, core_ppi}), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("hold_vld", 32'(rsp_vld), 32'd1);
      check("hold_rsp", 32'({rsp_ppo, rsp_po, rsp_fail}), 32'({rppo, rpo, rfail}));
      check("hold_rdy", 32'(start_rdy), 32'd0);
    end
    rsp_rdy = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_rdy = 1'b0; start_vld = 1'b0;
    check("done_vld", 32'(rsp_vld), 32'd0);
    check("done_rdy", 32'(start_rdy), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, 32'(start_rdy), 32'd1);
    check({tag, "_vld"}, 32'(rsp_vld), 32'd0);
    check({tag, "_rsp"}, 32'({rsp_ppo, rsp_po, rsp_fail}), 32'd0);
    check({tag, "_core"}, 32'({core_pi, core_ppi}), 32'd0);
    check({tag, "_cnt"}, {pat_cnt, fail_cnt}, 32'd0);
  endtask

  initial begin
    bit seen;
    logic [1:0] pi;
    logic [4:0] st;
    logic [3:0] eppo;
    logic       epo;
    start_vld = 0; rsp_rdy = 0; cnt_clr = 0;
    pat_pi = 0; pat_state = 0; exp_ppo = 0; exp_po = 0;
    start_vld1 = 0; pat_pi1 = 0; pat_state1 = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // directed: passing then failing pattern with a long response stall
    do_pat(2'b01, 5'b00101, 4'b1010, 1'b0, 0, 1'b0, 1'b0);
    do_pat(2'b01, 5'b00101, 4'b1010, 1'b1, 5, 1'b0, 1'b0);
    // start_vld held high across the whole transaction
    do_pat(2'b10, 5'b11010, 4'b0101, 1'b0, 2, 1'b1, 1'b0);

    // asynchronous reset in APPLY abandons the pattern
    pat_pi = 2'b11; pat_state = 5'b10011; exp_ppo = 4'b0000; exp_po = 1'b0;
    start_vld = 1'b1;
    @(posedge clk); @(negedge clk);
    start_vld = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async");
    pat_m = 0; fail_m = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_vld) seen = 1'b1;
    end
    check("no_rsp_after_rst", 32'(seen), 32'd0);
    check("cnt_after_rst", 32'(pat_cnt), 32'd0);
    do_pat(2'b00, 5'b01110, 4'b0001, 1'b1, 0, 1'b0, 1'b0);

    // randomized patterns, matching or random expectations
    for (int k = 0; k < 16; k++) begin
      pi = 2'($urandom); st = 5'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        eppo = ~st[3:0]; epo = pi[1] ^ st[4];
      end else begin
        eppo = 4'($urandom); epo = 1'($urandom);
      end
      do_pat(pi, st, eppo, epo, int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
    end

    // saturation from a preloaded near-full state, then clear on capture exit
    force u_dut.pat_cnt = 16'hFFFE;
    force u_dut.fail_cnt = 16'hFFFF;
    #1;
    release u_dut.pat_cnt;
    release u_dut.fail_cnt;
    pat_m = 65534; fail_m = 65535;
    for (int k = 0; k < 3; k++) begin
      pi = 2'($urandom); st = 5'($urandom);
      do_pat(pi, st, st[3:0], ~(pi[1] ^ st[4]), 0, 1'b0, 1'b0);
    end
    check("sat_pat", 32'(pat_cnt), 32'hFFFF);
    check("sat_fail", 32'(fail_cnt), 32'hFFFF);
    pi = 2'b01; st = 5'b00101;
    do_pat(pi, st, 4'b1111, 1'b1, 0, 1'b0, 1'b1);

    // back-to-back throughput with SETTLE_CYC=1 and rsp_rdy tied high
    start_vld1 = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); @(negedge clk);
      pat_pi1 = 2'($urandom); pat_state1 = 5'($urandom);
      check("tput_cnt", 32'(pat_cnt1), (k >= 3) ? 32'((k - 3) / 4 + 1) : 32'd0);
      check("tput_vld", 32'(rsp_vld1), 32'((k >= 3) && ((k - 3) % 4 == 0)));
    end
    start_vld1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/b01_scan_ctrl.md
B01_SCAN_CTRL -- requirements
Module: b01_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2: number of cycles the core inputs are held stable before capture; legal range 1..15.
REQ-002 CK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  asynchronous active-high reset.
REQ-004 start_vld  input  1  pattern request valid.
REQ-005 start_rdy  output  1  controller ready to accept a pattern.
REQ-006 pat_pi  input  2  primary input pair; bit0 drives G1, bit1 drives G2.
REQ-007 pat_state  input  5  present-state vector; bits 0..4 drive G112..G116.
REQ-008 exp_ppo  input  4  expected next-state; bits 0..3 correspond to G10..G13.
REQ-009 exp_po  input  1  expected primary output G24.
REQ-010 core_pi  output  2  to core G1/G2.
REQ-011 core_ppi  output  5  to core G112..G116.
REQ-012 core_ppo  input  4  from core G10..G13.
REQ-013 core_po  input  1  from core G24.
REQ-014 rsp_vld  output  1  response valid.
REQ-015 rsp_rdy  input  1  response consumer ready.
REQ-016 rsp_ppo  output  4  captured core_ppo.
REQ-017 rsp_po  output  1  captured core_po.
REQ-018 rsp_fail  output  1  captured {core_ppo,core_po} differs from {exp_ppo,exp_po}.
REQ-019 cnt_clr  input  1  synchronous clear of both counters.
REQ-020 pat_cnt  output  16  patterns completed, saturating.
REQ-021 fail_cnt  output  16  failing patterns, saturating.

Function
REQ-022 The FSM SHALL have exactly the states IDLE, APPLY, CAPTURE and RESP.
REQ-023 start_rdy SHALL be 1 only in IDLE; a pattern is accepted on an edge where start_vld=1 and start_rdy=1.
REQ-024 On acceptance, pat_pi, pat_state, exp_ppo and exp_po SHALL be registered and the FSM SHALL enter APPLY.
REQ-025 core_pi/core_ppi SHALL present the registered pattern in APPLY and CAPTURE, and SHALL be 0 in IDLE and RESP.
REQ-026 APPLY SHALL last exactly SETTLE_CYC cycles, counted by a 4-bit down-counter loaded with SETTLE_CYC-1, and SHALL then enter CAPTURE.
REQ-027 CAPTURE SHALL last one cycle; on its exit edge it SHALL register core_ppo into rsp_ppo, core_po into rsp_po, and the mismatch flag into rsp_fail; it SHALL then enter RESP.
REQ-028 rsp_vld SHALL be 1 only in RESP, i.e. first asserted SETTLE_CYC+2 edges after the accept edge.
REQ-029 rsp_ppo, rsp_po and rsp_fail SHALL stay stable while rsp_vld=1 and rsp_rdy=0.
REQ-030 RESP SHALL exit to IDLE on the edge where rsp_rdy=1; if rsp_rdy is already 1 on RESP entry, RESP lasts one cycle.
REQ-031 start_vld SHALL be ignored outside IDLE, and patterns SHALL NOT be queued.
REQ-032 pat_cnt SHALL increment by 1 on the CAPTURE exit edge; fail_cnt SHALL also increment on that edge when the mismatch flag is 1.
REQ-033 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-034 cnt_clr=1 SHALL zero both counters on that edge and SHALL take priority over a simultaneous increment; it SHALL NOT affect the FSM.
REQ-035 Minimum throughput SHALL be one pattern per SETTLE_CYC+3 cycles.

Reset
REQ-036 RST=1 SHALL immediately, without a clock edge, force state IDLE, all internal registers to 0, and outputs start_rdy=1, rsp_vld=0, rsp_ppo=0, rsp_po=0, rsp_fail=0, core_pi=0, core_ppi=0, pat_cnt=0, fail_cnt=0.
REQ-037 RST asserted mid-pattern SHALL abandon the pattern without issuing a response or updating the counters; after RST deasserts, the first edge with start_vld=1 SHALL accept a new pattern.

Verification
REQ-038 SETTLE_CYC=2; accept pat_pi=2'b01, pat_state=5'b00101; the core stub returns 4'b1010/0, and exp=4'b1010/0 -> rsp_vld rises 4 edges after accept, rsp_fail=0, pat_cnt=1, fail_cnt=0.
REQ-039 Same setup but exp_po=1 -> rsp_fail=1, fail_cnt=1; hold rsp_rdy=0 for 5 cycles -> rsp_* stable and start_rdy=0 throughout.
REQ-040 Drive start_vld=1 continuously during APPLY/CAPTURE/RESP -> exactly one pattern accepted; the next is accepted only after returning to IDLE.
REQ-041 Assert RST asynchronously in APPLY -> outputs reach reset values before the next CK edge; pat_cnt stays 0 and no rsp_vld pulse occurs.
REQ-042 Preload pat_cnt=16'hFFFE with fail_cnt=16'hFFFF; run 3 failing patterns -> both counters read 16'hFFFF; assert cnt_clr on a CAPTURE exit edge -> both counters read 0.
REQ-043 SETTLE_CYC=1 with rsp_rdy tied to 1 -> back-to-back patterns complete every 4 cycles.
